// File: rtl/halt_ctrl.sv
// Halt controller feeding the clock-gate hlt input: EBREAK/external halt, drain, resume,
// optional single-step compiled in with HALT_STEP_EN.
module halt_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        ext_halt_req,
    input  logic        resume_req,
    input  logic        step_req,
    output logic        hlt,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] halted_cycles
);

    // state  | meaning
    // RUN    | core running, watching for halt sources
    // DRAIN  | halt accepted, letting the pipeline empty
    // HALTED | gated clock blocked, waiting for resume/step
    // STEP   | one gated pulse released, then back to HALTED
`ifdef HALT_STEP_EN
    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;
`else
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
`endif

    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [3:0]  DRAIN_LD = 4'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  cause_d;
    logic [31:0] cycles_d;
    logic        halted_d;
    logic        ebreak;

    assign ebreak = instr_valid && (instr == EBREAK);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = halt_cause;
        cycles_d = halted_cycles;
        unique case (state_q)
            RUN: begin
                if (ebreak || ext_halt_req) begin
                    cause_d  = ebreak ? 2'b01 : 2'b10;
                    cnt_d    = DRAIN_LD;
                    cycles_d = 32'd0;
                    state_d  = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (halted_cycles != 32'hFFFF_FFFF) begin
                    cycles_d = halted_cycles + 32'd1;
                end
                if (resume_req) begin
                    state_d = RUN;
                    cause_d = 2'b00;
                end
`ifdef HALT_STEP_EN
                else if (step_req) begin
                    state_d = STEP;
                end
`endif
            end
`ifdef HALT_STEP_EN
            STEP: begin
                state_d = HALTED;
                cause_d = 2'b11;
            end
`endif
            default: state_d = RUN;
        endcase
    end

`ifdef HALT_STEP_EN
    assign halted_d = (state_d == HALTED) || (state_d == STEP);
`else
    assign halted_d = (state_d == HALTED);
    logic unused_step;
    assign unused_step = step_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            halt_cause    <= 2'b00;
            halted_cycles <= 32'd0;
            halted        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            halt_cause    <= cause_d;
            halted_cycles <= cycles_d;
            halted        <= halted_d;
        end
    end

    // Falling-edge flop: hlt only moves while clk is low, so ~hlt & clk cannot glitch.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hlt <= 1'b0;
        end else begin
            hlt <= (state_q == HALTED);
        end
    end

endmodule

// File: tb/tb_halt_ctrl.sv
// Scoreboard bench for halt_ctrl: three instances (DRAIN_CYCLES 2, 0, 5) share random stimulus
// and are checked against a behavioural model; step checks follow HALT_STEP_EN.
`timescale 1ns/1ps
module tb_halt_ctrl;

    localparam int N = 3;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
`ifdef HALT_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]       hlt;
        logic [N-1:0]       halted;
        logic [N-1:0]       pulse;
        logic [N-1:0][1:0]  cause;
        logic [N-1:0][31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        ext_halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        step_req = 1'b0;

    logic [N-1:0] hlt_w;
    logic [N-1:0] halted_w;
    logic [1:0]   cause_w [N];
    logic [31:0]  cyc_w [N];
    wire  [N-1:0] gclk = {N{clk}} & ~hlt_w;

    always #5 clk = ~clk;

    halt_ctrl #(.DRAIN_CYCLES(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .ext_halt_req(ext_halt_req), .resume_req(resume_req), .step_req(step_req),
        .hlt(hlt_w[0]), .halted(halted_w[0]), .halt_cause(cause_w[0]), .halted_cycles(cyc_w[0]));
    halt_ctrl #(.DRAIN_CYCLES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .ext_halt_req(ext_halt_req), .resume_req(resume_req), .step_req(step_req),
        .hlt(hlt_w[1]), .halted(halted_w[1]), .halt_cause(cause_w[1]), .halted_cycles(cyc_w[1]));
    halt_ctrl #(.DRAIN_CYCLES(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .ext_halt_req(ext_halt_req), .resume_req(resume_req), .step_req(step_req),
        .hlt(hlt_w[2]), .halted(halted_w[2]), .halt_cause(cause_w[2]), .halted_cycles(cyc_w[2]));

    int pc0 = 0, pc1 = 0, pc2 = 0;
    always @(posedge gclk[0]) pc0++;
    always @(posedge gclk[1]) pc1++;
    always @(posedge gclk[2]) pc2++;

    int glitch_cnt = 0;
    always @(hlt_w) if (clk === 1'b1 && rst_n === 1'b1) glitch_cnt++;

    exp_t sb[$];
    bit   rst_fresh = 1'b0;
    bit   done = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference model: drain_left < 0 running, > 0 draining, 0 halted (in_step marks the released pulse)
    int      m_drain [N];
    bit      m_step  [N];
    logic [1:0] m_cause [N];
    longint  m_cyc   [N];

    function automatic int drain_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 5);
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [31:0] i,
                         input logic e, input logic rs, input logic s);
        exp_t ex;
        logic eb;
        @(negedge clk);
        #2;
        rst_fresh    = rst_n && !r;
        rst_n        = r;
        instr_valid  = v;
        instr        = i;
        ext_halt_req = e;
        resume_req   = rs;
        step_req     = s;
        eb = v && (i == EBREAK);
        ex = '0;
        for (int k = 0; k < N; k++) begin
            if (!r) begin
                m_drain[k] = -1; m_step[k] = 1'b0; m_cause[k] = 2'd0; m_cyc[k] = 0;
            end
            ex.pulse[k] = !(m_drain[k] == 0 && !m_step[k]);
            if (r) begin
                if (m_step[k]) begin
                    m_step[k]  = 1'b0;
                    m_cause[k] = 2'd3;
                end else if (m_drain[k] < 0) begin
                    if (eb || e) begin
                        m_cause[k] = eb ? 2'd1 : 2'd2;
                        m_cyc[k]   = 0;
                        m_drain[k] = drain_of(k);
                    end
                end else if (m_drain[k] > 0) begin
                    m_drain[k]--;
                end else begin
                    if (m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
                    if (rs) begin
                        m_drain[k] = -1;
                        m_cause[k] = 2'd0;
                    end else if (STEP_EN && s) begin
                        m_step[k] = 1'b1;
                    end
                end
            end
            ex.hlt[k]    = (m_drain[k] == 0) && !m_step[k];
            ex.halted[k] = (m_drain[k] == 0);
            ex.cause[k]  = m_cause[k];
            ex.cyc[k]    = 32'(m_cyc[k]);
        end
        sb.push_back(ex);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, req, $time);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 1'b1, EBREAK, 1'b0, 1'b0, 1'b0);
        idle(8);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(7);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        cycle(1'b1, 1'b1, EBREAK, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) cycle(1'b1, 1'b1, EBREAK, 1'b1, 1'b0, 1'b0);
        idle(25);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(3);
        cycle(1'b1, 1'b1, ECALL, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, 1'b1, EBREAK, 1'b0, 1'b0, 1'b0);
        idle(8);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(4);
        for (int j = 0; j < 7; j++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        // reset while DRAIN (d2, d5) and HALTED (d0)
        cycle(1'b1, 1'b1, EBREAK, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, 1'b1, EBREAK, 1'b0, 1'b0, 1'b0);
        idle(8);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        // reset while every instance is HALTED
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(9);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int j = 0; j < 1500; j++) begin
            int  sel;
            logic [31:0] w;
            sel = int'($urandom_range(0, 9));
            w = (sel < 2) ? EBREAK : ((sel == 2) ? ECALL : $urandom);
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, w,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0);
        end
        idle(2);
        done = 1'b1;
    end

    initial begin
        exp_t ex;
        int pc_prev [N];
        int pc_now  [N];
        @(negedge clk);
        #1;
        pc_prev = '{pc0, pc1, pc2};
        while (!(done && sb.size() == 0)) begin
            @(negedge clk);
            #1;
            pc_now = '{pc0, pc1, pc2};
            if (sb.size() > 0) begin
                ex = sb.pop_front();
                for (int k = 0; k < N; k++) begin
                    chk("hlt", k, 32'(hlt_w[k]), 32'(ex.hlt[k]));
                    chk("halted", k, 32'(halted_w[k]), 32'(ex.halted[k]));
                    chk("halt_cause", k, 32'(cause_w[k]), 32'(ex.cause[k]));
                    chk("halted_cycles", k, cyc_w[k], ex.cyc[k]);
                    chk("gated_pulses", k, 32'(pc_now[k] - pc_prev[k]), 32'(ex.pulse[k]));
                end
            end
            pc_prev = pc_now;
            #2;
            if (rst_fresh) begin
                for (int k = 0; k < N; k++) begin
                    chk("async_rst_hlt", k, 32'(hlt_w[k]), 32'd0);
                    chk("async_rst_halted", k, 32'(halted_w[k]), 32'd0);
                    chk("async_rst_cause", k, 32'(cause_w[k]), 32'd0);
                    chk("async_rst_cycles", k, cyc_w[k], 32'd0);
                end
            end
        end
        chk("hlt_change_while_clk_high", 0, 32'(glitch_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
